// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 capture front end: FSM states,
// default crop size and the RGB444 pixel layout used by the frame buffer.
package ov7670_pkg;

   typedef enum logic [1:0] {
      WAIT_VS = 2'd0,
      VBLANK  = 2'd1,
      CAPTURE = 2'd2
   } capState_e;

   localparam int DEF_IMG_W = 320;
   localparam int DEF_IMG_H = 200;

   localparam int PIX_W = 12;
   localparam int CH_W  = 4;
   localparam int R_LSB = 8;
   localparam int G_LSB = 4;
   localparam int B_LSB = 0;

   // Places the three 4-bit channels into a 12-bit {R,G,B} word.
   function automatic logic [PIX_W-1:0] packRgb444(input logic [CH_W-1:0] r,
                                                   input logic [CH_W-1:0] g,
                                                   input logic [CH_W-1:0] b);
      logic [PIX_W-1:0] p;
      p = '0;
      p[R_LSB +: CH_W] = r;
      p[G_LSB +: CH_W] = g;
      p[B_LSB +: CH_W] = b;
      return p;
   endfunction

endpackage

// File: rtl/ov7670_byte_pair.sv
// Pairs consecutive camera bytes into RGB444 pixels. The first byte of a
// pair carries red in its low nibble, the second carries green and blue.
module ov7670_byte_pair
   import ov7670_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             href_i,
   input  logic [7:0]       d_i,
   output logic             pixValid_o,
   output logic [PIX_W-1:0] pix_o
);

   logic            phase_q;
   logic [CH_W-1:0] hi_q;

   // Track which byte of the pair is on d_i; any gap in href or loss of
   // enable restarts pairing so a stray odd byte never leaks into a pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= 1'b0;
         hi_q    <= '0;
      end else if (en_i && href_i) begin
         phase_q <= ~phase_q;
         if (!phase_q) begin
            hi_q <= d_i[3:0];
         end
      end else begin
         phase_q <= 1'b0;
      end
   end

   assign pixValid_o = en_i & href_i & phase_q;
   assign pix_o      = packRgb444(hi_q, d_i[7:4], d_i[3:0]);

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture stage: registers the camera bus, assembles RGB444 pixels,
// crops to IMG_W x IMG_H and writes them at linear raster addresses.
module ov7670_capture
   import ov7670_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int AW    = 16
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          vsync,
   input  logic          href,
   input  logic [7:0]    d,
   output logic [AW-1:0] waddr,
   output logic          we,
   output logic [11:0]   pixout,
   output logic          frame_done,
   output logic [8:0]    line_cnt
);

   localparam logic [AW-1:0] IMG_W_A = AW'(IMG_W);
   localparam logic [8:0]    IMG_H_L = 9'(IMG_H);

   logic            vsync_q;
   logic            href_q;
   logic            hrefPrev_q;
   logic [7:0]      d_q;

   capState_e       state_q;
   logic [AW-1:0]   col_q;
   logic [AW-1:0]   lineBase_q;
   logic [8:0]      lineCnt_q;
   logic [AW-1:0]   waddr_q;
   logic            we_q;
   logic [11:0]     pixout_q;
   logic            frameDone_q;

   logic            capEn;
   logic            pixValid;
   logic [11:0]     pix;
   logic [AW-1:0]   colInc_d;
   logic [AW-1:0]   waddr_d;
   logic            storeOk_d;
   logic            lineEnd_d;
   logic            lineCounts_d;

   // Single input register stage; every decision below looks only at these.
   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_q    <= 1'b0;
         href_q     <= 1'b0;
         hrefPrev_q <= 1'b0;
         d_q        <= '0;
      end else begin
         vsync_q    <= vsync;
         href_q     <= href;
         hrefPrev_q <= href_q;
         d_q        <= d;
      end
   end

   // vsync overrides href, so pairing is only live in CAPTURE outside blank.
   assign capEn = (state_q == CAPTURE) && !vsync_q;

   ov7670_byte_pair uBytePair (
      .clk        (clk),
      .rst        (rst),
      .en_i       (capEn),
      .href_i     (href_q),
      .d_i        (d_q),
      .pixValid_o (pixValid),
      .pix_o      (pix)
   );

   // Column saturation, crop window test and line-end detection.
   always_comb begin
      colInc_d     = (col_q < IMG_W_A) ? col_q + 1'b1 : col_q;
      waddr_d      = lineBase_q + col_q;
      storeOk_d    = (col_q < IMG_W_A) && (lineCnt_q < IMG_H_L);
      lineEnd_d    = capEn && !href_q && hrefPrev_q;
      lineCounts_d = (col_q != '0) && (lineCnt_q < IMG_H_L);
   end

   // Frame FSM with registered write port, line counters and frame pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= WAIT_VS;
         col_q       <= '0;
         lineBase_q  <= '0;
         lineCnt_q   <= '0;
         waddr_q     <= '0;
         we_q        <= 1'b0;
         pixout_q    <= '0;
         frameDone_q <= 1'b0;
      end else begin
         we_q        <= 1'b0;
         frameDone_q <= 1'b0;
         unique case (state_q)
            WAIT_VS: begin
               if (vsync_q) begin
                  state_q <= VBLANK;
               end
            end
            VBLANK: begin
               if (!vsync_q) begin
                  state_q    <= CAPTURE;
                  lineCnt_q  <= '0;
                  col_q      <= '0;
                  lineBase_q <= '0;
               end
            end
            CAPTURE: begin
               if (vsync_q) begin
                  frameDone_q <= 1'b1;
                  state_q     <= VBLANK;
               end else if (pixValid) begin
                  if (storeOk_d) begin
                     we_q     <= 1'b1;
                     pixout_q <= pix;
                     waddr_q  <= waddr_d;
                  end
                  col_q <= colInc_d;
               end else if (lineEnd_d) begin
                  if (lineCounts_d) begin
                     lineBase_q <= lineBase_q + IMG_W_A;
                     lineCnt_q  <= lineCnt_q + 9'd1;
                  end
                  col_q <= '0;
               end
            end
            default: begin
               state_q <= WAIT_VS;
            end
         endcase
      end
   end

   assign waddr      = waddr_q;
   assign we         = we_q;
   assign pixout     = pixout_q;
   assign frame_done = frameDone_q;
   assign line_cnt   = lineCnt_q;

endmodule
